// File: rtl/intr_src_conditioner.sv
// rtl/intr_src_conditioner.sv - synchronise, filter, invert and level/edge-condition raw interrupt lines
module intr_src_conditioner #(
  parameter int                   num_src_p       = 2,
  parameter int                   sync_stages_p   = 2,
  parameter int                   filter_cycles_p = 4,
  parameter int                   pulse_cycles_p  = 4,
  parameter logic [num_src_p-1:0] edge_mask_p     = '0,
  parameter logic [num_src_p-1:0] invert_mask_p   = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_src_p-1:0] intr_raw_i,
  output logic [num_src_p-1:0] intr_src_o,
  output logic [num_src_p-1:0] dropped_o
);

  localparam int cw = $clog2(filter_cycles_p + 1);
  localparam int pw = $clog2(pulse_cycles_p + 1);
  localparam logic [cw-1:0] c_last = cw'(filter_cycles_p - 1);
  localparam logic [pw-1:0] p_load = pw'(pulse_cycles_p);

  if (sync_stages_p < 2) begin : g_chk_sync
    $error("intr_src_conditioner: sync_stages_p must be at least 2");
  end
  if (filter_cycles_p < 1) begin : g_chk_filter
    $error("intr_src_conditioner: filter_cycles_p must be at least 1");
  end
  if (pulse_cycles_p < 1) begin : g_chk_pulse
    $error("intr_src_conditioner: pulse_cycles_p must be at least 1");
  end

  for (genvar i = 0; i < num_src_p; i++) begin : g_src
    logic [sync_stages_p-1:0] sync_q;
    logic                     s;
    logic                     f_q, f_d;
    logic [cw-1:0]            c_q, c_d;

    // Metastability chain: bit 0 takes the raw pin, the top bit is the clean sample.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= {sync_q[sync_stages_p-2:0], intr_raw_i[i]};
    end

    // Polarity is applied after the chain, so an active-low pin still waits out the full latency after reset.
    assign s = sync_q[sync_stages_p-1] ^ invert_mask_p[i];

    // Filter next state: accept a new value only after filter_cycles_p consecutive differing samples.
    always_comb begin
      f_d = f_q;
      c_d = '0;
      if (s != f_q) begin
        if (c_q == c_last) f_d = s;
        else               c_d = c_q + cw'(1);
      end
    end

    // Filter state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        f_q <= 1'b0;
        c_q <= '0;
      end else begin
        f_q <= f_d;
        c_q <= c_d;
      end
    end

    if (edge_mask_p[i]) begin : g_edge
      logic          rise;
      logic [pw-1:0] p_q, p_d;
      logic          out_q, drop_q;

      assign rise = ~f_q & f_d;

      // Stretch counter: a rise (re)loads the full width, otherwise count down to idle.
      always_comb begin
        p_d = p_q;
        if (rise)            p_d = p_load;
        else if (p_q != '0)  p_d = p_q - pw'(1);
      end

      // Output and drop flags are registered from next-state so they align with the reload edge.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          p_q    <= '0;
          out_q  <= 1'b0;
          drop_q <= 1'b0;
        end else begin
          p_q    <= p_d;
          out_q  <= (p_d != '0);
          // A rise on the last pulse cycle is a seamless extension, not a merged event.
          drop_q <= rise && (p_q > pw'(1));
        end
      end

      assign intr_src_o[i] = out_q;
      assign dropped_o[i]  = drop_q;
    end else begin : g_level
      assign intr_src_o[i] = f_q;
      assign dropped_o[i]  = 1'b0;
    end
  end

endmodule

// File: tb/tb_intr_src_conditioner.sv
// tb/tb_intr_src_conditioner.sv - directed self-checking bench for intr_src_conditioner
module tb_intr_src_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] raw_a, raw_b, raw_c, raw_d;
  logic [1:0] out_a, out_b, out_c, out_d;
  logic [1:0] drop_a, drop_b, drop_c, drop_d;

  int checks = 0;
  int errors = 0;

  logic [1:0] pat[$];
  int sel;

  int hi_a0, hi_a1, first_a, last_a;
  int hi_b0, hi_b1, first_b, last_b, dr_b;
  int hi_c0, hi_c1, first_c, last_c, dr_c, drop_step_c;
  int hi_d0, hi_d1, first_d0, first_d1, last_d0, last_d1;
  int dr_other;

  // level mode, defaults
  intr_src_conditioner dut_a (
    .clk_i(clk), .reset_i(rst), .intr_raw_i(raw_a), .intr_src_o(out_a), .dropped_o(drop_a)
  );
  // source 0 edge mode, defaults
  intr_src_conditioner #(.edge_mask_p(2'b01)) dut_b (
    .clk_i(clk), .reset_i(rst), .intr_raw_i(raw_b), .intr_src_o(out_b), .dropped_o(drop_b)
  );
  // source 0 edge mode, single-sample filter so retriggers can land inside a pulse
  intr_src_conditioner #(.filter_cycles_p(1), .pulse_cycles_p(4), .edge_mask_p(2'b01)) dut_c (
    .clk_i(clk), .reset_i(rst), .intr_raw_i(raw_c), .intr_src_o(out_c), .dropped_o(drop_c)
  );
  // source 1 active-low
  intr_src_conditioner #(.invert_mask_p(2'b10)) dut_d (
    .clk_i(clk), .reset_i(rst), .intr_raw_i(raw_d), .intr_src_o(out_d), .dropped_o(drop_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v);
    case (sel)
      0:       raw_a = v;
      1:       raw_b = v;
      2:       raw_c = v;
      default: raw_d = v;
    endcase
  endtask

  task automatic mk(input logic [1:0] v, input int n);
    repeat (n) pat.push_back(v);
  endtask

  // Play pat on the selected instance (one entry per clock) and record output statistics over n clocks.
  task automatic win(input int n);
    hi_a0 = 0; hi_a1 = 0; first_a = -1; last_a = -1;
    hi_b0 = 0; hi_b1 = 0; first_b = -1; last_b = -1; dr_b = 0;
    hi_c0 = 0; hi_c1 = 0; first_c = -1; last_c = -1; dr_c = 0; drop_step_c = -1;
    hi_d0 = 0; hi_d1 = 0; first_d0 = -1; first_d1 = -1; last_d0 = -1; last_d1 = -1;
    dr_other = 0;
    for (int k = 1; k <= n; k++) begin
      if (k <= pat.size()) drive(pat[k-1]);
      step();
      if (out_a[0]) begin hi_a0++; if (first_a < 0) first_a = k; last_a = k; end
      if (out_a[1]) hi_a1++;
      if (out_b[0]) begin hi_b0++; if (first_b < 0) first_b = k; last_b = k; end
      if (out_b[1]) hi_b1++;
      if (drop_b[0]) dr_b++;
      if (out_c[0]) begin hi_c0++; if (first_c < 0) first_c = k; last_c = k; end
      if (out_c[1]) hi_c1++;
      if (drop_c[0]) begin dr_c++; drop_step_c = k; end
      if (out_d[0]) begin hi_d0++; if (first_d0 < 0) first_d0 = k; last_d0 = k; end
      if (out_d[1]) begin hi_d1++; if (first_d1 < 0) first_d1 = k; last_d1 = k; end
      if (drop_a != 2'b00 || drop_b[1] || drop_c[1] || drop_d != 2'b00) dr_other++;
    end
    pat.delete();
  endtask

  initial begin
    rst = 1'b1;
    raw_a = 2'b00; raw_b = 2'b00; raw_c = 2'b00; raw_d = 2'b10;
    sel = 0;

    // reset state
    #3;
    chk("reset_out_a", 32'(out_a), 32'd0);
    chk("reset_out_d", 32'(out_d), 32'd0);
    repeat (3) step();
    chk("reset_hold_out", 32'(out_a | out_b | out_c | out_d), 32'd0);
    chk("reset_hold_drop", 32'(drop_a | drop_b | drop_c | drop_d), 32'd0);
    rst = 1'b0;
    repeat (12) step();
    chk("idle_inverted_stays_low", 32'(out_d), 32'd0);

    // asynchronous reset mid-operation, then release latency
    raw_a = 2'b11;
    repeat (8) step();
    chk("level_on_before_reset", 32'(out_a), 32'd3);
    #2 rst = 1'b1;
    #1 chk("reset_async_clear", 32'(out_a), 32'd0);
    #2 rst = 1'b0;
    repeat (5) step();
    chk("reset_release_edge5", 32'(out_a), 32'd0);
    step();
    chk("reset_release_edge6", 32'(out_a), 32'd3);
    raw_a = 2'b00;
    repeat (12) step();
    chk("level_off_after_release", 32'(out_a), 32'd0);

    // glitch rejection: 3-cycle pulse filtered, 4-cycle pulse passes as 4 cycles
    sel = 0;
    mk(2'b11, 3); mk(2'b00, 1);
    win(20);
    chk("glitch3_src0", 32'(hi_a0), 32'd0);
    chk("glitch3_src1", 32'(hi_a1), 32'd0);
    mk(2'b11, 4); mk(2'b00, 1);
    win(20);
    chk("pulse4_src0_len", 32'(hi_a0), 32'd4);
    chk("pulse4_src1_len", 32'(hi_a1), 32'd4);
    chk("pulse4_first", 32'(first_a), 32'd6);
    chk("pulse4_last", 32'(last_a), 32'd9);

    // chatter: 2 high / 2 low for 40 cycles never gets through
    for (int r = 0; r < 10; r++) begin
      mk(2'b11, 2); mk(2'b00, 2);
    end
    win(50);
    chk("chatter_src0", 32'(hi_a0), 32'd0);
    chk("chatter_src1", 32'(hi_a1), 32'd0);

    // edge mode: 100-cycle high gives one 4-cycle pulse, nothing on the fall
    sel = 1;
    mk(2'b01, 100); mk(2'b00, 1);
    win(115);
    chk("edge_len", 32'(hi_b0), 32'd4);
    chk("edge_first", 32'(first_b), 32'd6);
    chk("edge_last", 32'(last_b), 32'd9);
    chk("edge_level_src_quiet", 32'(hi_b1), 32'd0);
    chk("edge_no_drop", 32'(dr_b), 32'd0);

    // retrigger while p=3: one drop, output continuous through the reload
    sel = 2;
    mk(2'b01, 1); mk(2'b00, 1); mk(2'b01, 6); mk(2'b00, 1);
    win(20);
    chk("retrig_len", 32'(hi_c0), 32'd6);
    chk("retrig_first", 32'(first_c), 32'd3);
    chk("retrig_last", 32'(last_c), 32'd8);
    chk("retrig_drop_count", 32'(dr_c), 32'd1);
    chk("retrig_drop_step", 32'(drop_step_c), 32'd5);

    // retrigger while p=1: seamless extension, no drop
    mk(2'b01, 1); mk(2'b00, 3); mk(2'b01, 4); mk(2'b00, 1);
    win(20);
    chk("ext_len", 32'(hi_c0), 32'd8);
    chk("ext_first", 32'(first_c), 32'd3);
    chk("ext_last", 32'(last_c), 32'd10);
    chk("ext_no_drop", 32'(dr_c), 32'd0);
    chk("ext_level_src_quiet", 32'(hi_c1), 32'd0);

    // inversion and parallelism: raw1 low and raw0 high on the same edge
    sel = 3;
    mk(2'b01, 10); mk(2'b10, 1);
    win(25);
    chk("inv_first_src0", 32'(first_d0), 32'd6);
    chk("inv_first_src1", 32'(first_d1), 32'd6);
    chk("inv_last_src0", 32'(last_d0), 32'd15);
    chk("inv_last_src1", 32'(last_d1), 32'd15);
    chk("inv_len_src1", 32'(hi_d1), 32'd10);
    chk("level_drops_tied_low", 32'(dr_other), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
